// File: rtl/spin_flip_scanner.sv
// spin_flip_scanner
//   Sits downstream of the energy-monitor vector cache. For each accepted spin
//   vector it XORs the new vector with the previously cached one, then streams
//   every flipped spin (index + new value, lowest index first) over a
//   valid/ready interface and finally pulses done_o with the flip count held
//   on flip_cnt_o.
//
// Parameters
//   DATAWIDTH  spin vector width (>= 2)
//   IDXWIDTH   flip index width
//   CNTWIDTH   flip count width
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_i                   block enable; low clears the scanner to IDLE
//   data_valid_i/_ready_o  vector handshake; data_i new vector,
//                          data_cached_i previous vector from the cache
//   flip_valid_o/_ready_i  flip handshake; flip_idx_o, flip_val_o,
//                          flip_last_o describe the current flip
//   flip_cnt_o             flips emitted for the current/last vector
//   done_o                 one-cycle pulse when a vector is fully scanned
//   busy_o                 scanner not in IDLE
//   perf_stall_cnt_o       flip back-pressure cycle counter
//
// Optional feature macro: SPIN_FLIP_SCANNER_PERF_EN
//   defined   -> perf_stall_cnt_o counts cycles with flip_valid_o & !flip_ready_i
//   undefined -> perf_stall_cnt_o tied to zero, no counter flops
module spin_flip_scanner #(
  parameter int DATAWIDTH = 256,
  parameter int IDXWIDTH  = $clog2(DATAWIDTH),
  parameter int CNTWIDTH  = $clog2(DATAWIDTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic [DATAWIDTH-1:0] data_cached_i,
  output logic                 flip_valid_o,
  input  logic                 flip_ready_i,
  output logic [IDXWIDTH-1:0]  flip_idx_o,
  output logic                 flip_val_o,
  output logic                 flip_last_o,
  output logic [CNTWIDTH-1:0]  flip_cnt_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [31:0]          perf_stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATAWIDTH-1:0]  mask_q, mask_d;
  logic [DATAWIDTH-1:0]  vec_q, vec_d;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;

  logic [DATAWIDTH-1:0]  new_mask;
  logic [DATAWIDTH-1:0]  mask_rest;   // mask_q with its lowest set bit cleared
  logic [IDXWIDTH-1:0]   low_idx;
  logic                  found;

  assign new_mask  = data_i ^ data_cached_i;
  assign mask_rest = mask_q & (mask_q - DATAWIDTH'(1));

  // Lowest-set-bit priority encoder over the pending flip mask.
  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < DATAWIDTH; i++) begin
      if (mask_q[i] && !found) begin
        low_idx = IDXWIDTH'(i);
        found   = 1'b1;
      end
    end
  end

  // en_i gates the outward strobes combinationally so they drop in the very
  // cycle the block is disabled; flip_ready_i never feeds these.
  assign data_ready_o = en_i && (state_q == IDLE);
  assign flip_valid_o = en_i && (state_q == SCAN);
  assign flip_idx_o   = low_idx;
  assign flip_val_o   = vec_q[low_idx];
  assign flip_last_o  = flip_valid_o && (mask_rest == '0);
  assign flip_cnt_o   = cnt_q;
  assign done_o       = en_i && (state_q == DONE);
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = IDLE;
      mask_d  = '0;
      vec_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_valid_i) begin
            mask_d  = new_mask;
            vec_d   = data_i;
            cnt_d   = '0;
            state_d = (new_mask != '0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (flip_ready_i) begin
            mask_d = mask_rest;
            cnt_d  = cnt_q + CNTWIDTH'(1);
            if (mask_rest == '0) state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SPIN_FLIP_SCANNER_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!en_i) begin
      stall_d = '0;
    end else if (flip_valid_o && !flip_ready_i) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cnt_o = stall_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spin_flip_scanner.sv
// Bench for spin_flip_scanner: an 8-bit instance for directed and random
// vectors, plus a 256-bit instance for the all-spins-flipped case.
module tb_spin_flip_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;

  // 8-bit instance
  logic       dvalid, dready, fvalid, fready, fval, flast, done, busy;
  logic [7:0] data, cached;
  logic [2:0] fidx;
  logic [3:0] fcnt;
  logic [31:0] perf;

  // 256-bit instance
  logic         b_dvalid, b_dready, b_fvalid, b_fready, b_fval, b_flast, b_done, b_busy;
  logic [255:0] b_data, b_cached;
  logic [7:0]   b_fidx;
  logic [8:0]   b_fcnt;
  logic [31:0]  b_perf;

  spin_flip_scanner #(.DATAWIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .data_valid_i(dvalid), .data_ready_o(dready),
    .data_i(data), .data_cached_i(cached),
    .flip_valid_o(fvalid), .flip_ready_i(fready),
    .flip_idx_o(fidx), .flip_val_o(fval), .flip_last_o(flast),
    .flip_cnt_o(fcnt), .done_o(done), .busy_o(busy),
    .perf_stall_cnt_o(perf)
  );

  spin_flip_scanner #(.DATAWIDTH(256)) u_dut256 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .data_valid_i(b_dvalid), .data_ready_o(b_dready),
    .data_i(b_data), .data_cached_i(b_cached),
    .flip_valid_o(b_fvalid), .flip_ready_i(b_fready),
    .flip_idx_o(b_fidx), .flip_val_o(b_fval), .flip_last_o(b_flast),
    .flip_cnt_o(b_fcnt), .done_o(b_done), .busy_o(b_busy),
    .perf_stall_cnt_o(b_perf)
  );

  int checks = 0;
  int fails  = 0;
  logic [31:0] perf_model = '0;   // stall cycles seen by the 8-bit instance

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] m);
`ifdef SPIN_FLIP_SCANNER_PERF_EN
    return m;
`else
    return 32'd0;
`endif
  endfunction

  // Reference: the flip list is simply every differing bit, ascending.
  // forced_stalls >= 0 holds ready low that many cycles per flip; < 0 randomizes.
  task automatic run_vec(input logic [7:0] d, input logic [7:0] c, input int forced_stalls);
    int   q_idx[$];
    logic q_val[$];
    int   n  = 0;
    int   st = 0;
    for (int i = 0; i < 8; i++)
      if (d[i] != c[i]) begin
        q_idx.push_back(i);
        q_val.push_back(d[i]);
      end
    @(negedge clk);
    check_eq("ready_idle", 64'(dready), 64'd1);
    dvalid = 1'b1; data = d; cached = c;
    @(negedge clk);
    dvalid = 1'b0; data = 8'($urandom); cached = 8'($urandom);
    while (q_idx.size() > 0) begin
      check_eq("flip_valid", 64'(fvalid), 64'd1);
      check_eq("flip_idx",   64'(fidx),   64'(q_idx[0]));
      check_eq("flip_val",   64'(fval),   64'(q_val[0]));
      check_eq("flip_last",  64'(flast),  64'(q_idx.size() == 1));
      check_eq("cnt_scan",   64'(fcnt),   64'(n));
      check_eq("ready_scan", 64'(dready), 64'd0);
      check_eq("done_scan",  64'(done),   64'd0);
      if (forced_stalls >= 0) fready = (st >= forced_stalls);
      else                    fready = ($urandom_range(3) != 0) || (st >= 6);
      if (fready) begin
        void'(q_idx.pop_front());
        void'(q_val.pop_front());
        n++;
        st = 0;
      end else begin
        st++;
        perf_model++;
      end
      @(negedge clk);
    end
    check_eq("done_pulse",  64'(done),   64'd1);
    check_eq("valid_done",  64'(fvalid), 64'd0);
    check_eq("cnt_done",    64'(fcnt),   64'(n));
    check_eq("perf",        64'(perf),   64'(perf_exp(perf_model)));
    @(negedge clk);
    check_eq("done_one",    64'(done),   64'd0);
    check_eq("busy_idle",   64'(busy),   64'd0);
    check_eq("ready_back",  64'(dready), 64'd1);
    check_eq("cnt_hold",    64'(fcnt),   64'(n));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    dvalid = 1'b0; fready = 1'b1; data = '0; cached = '0;
    b_dvalid = 1'b0; b_fready = 1'b1; b_data = '0; b_cached = '0;
    #12;
    check_eq("rst_valid", 64'(fvalid), 64'd0);
    check_eq("rst_last",  64'(flast),  64'd0);
    check_eq("rst_done",  64'(done),   64'd0);
    check_eq("rst_busy",  64'(busy),   64'd0);
    check_eq("rst_cnt",   64'(fcnt),   64'd0);
    check_eq("rst_perf",  64'(perf),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec(8'hA5, 8'h00, 0);
    run_vec(8'h3C, 8'h3C, 0);
    run_vec(8'h7F, 8'hFF, 3);

    // Disable after the second flip is accepted.
    @(negedge clk);
    dvalid = 1'b1; data = 8'hF0; cached = 8'h00; fready = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    check_eq("en_idx4", 64'(fidx), 64'd4);
    @(negedge clk);
    check_eq("en_idx5", 64'(fidx), 64'd5);
    @(negedge clk);
    check_eq("en_idx6", 64'(fidx), 64'd6);
    check_eq("en_cnt2", 64'(fcnt), 64'd2);
    en = 1'b0;
    #1;
    check_eq("en_valid_drop", 64'(fvalid), 64'd0);
    check_eq("en_no_done",    64'(done),   64'd0);
    check_eq("en_no_ready",   64'(dready), 64'd0);
    @(negedge clk);
    check_eq("en_busy",  64'(busy),  64'd0);
    check_eq("en_cnt",   64'(fcnt),  64'd0);
    check_eq("en_done",  64'(done),  64'd0);
    en = 1'b1;
    perf_model = '0;
    #1;
    check_eq("en_ready_back", 64'(dready), 64'd1);
    check_eq("en_perf_clr",   64'(perf),   64'd0);

    // Asynchronous reset mid-scan.
    @(negedge clk);
    dvalid = 1'b1; data = 8'h0F; cached = 8'h00; fready = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    check_eq("rs_idx0", 64'(fidx), 64'd0);
    @(negedge clk);
    check_eq("rs_idx1", 64'(fidx), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rs_valid", 64'(fvalid), 64'd0);
    check_eq("rs_last",  64'(flast),  64'd0);
    check_eq("rs_busy",  64'(busy),   64'd0);
    check_eq("rs_cnt",   64'(fcnt),   64'd0);
    check_eq("rs_done",  64'(done),   64'd0);
    check_eq("rs_perf",  64'(perf),   64'd0);
    perf_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(8'h01, 8'h00, 0);
    run_vec(8'hFF, 8'h00, -1);

    for (int k = 0; k < 40; k++)
      run_vec(8'($urandom), 8'($urandom), -1);

    // Wide instance: every spin flips.
    @(negedge clk);
    b_dvalid = 1'b1; b_data = '1; b_cached = '0; b_fready = 1'b1;
    @(negedge clk);
    b_dvalid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      check_eq("w_valid", 64'(b_fvalid), 64'd1);
      check_eq("w_idx",   64'(b_fidx),   64'(i));
      check_eq("w_val",   64'(b_fval),   64'd1);
      check_eq("w_last",  64'(b_flast),  64'(i == 255));
      @(negedge clk);
    end
    check_eq("w_done", 64'(b_done), 64'd1);
    check_eq("w_cnt",  64'(b_fcnt), 64'd256);
    check_eq("w_perf", 64'(b_perf), 64'd0);
    @(negedge clk);
    check_eq("w_done_one", 64'(b_done), 64'd0);
    check_eq("w_busy",     64'(b_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/spin_flip_scanner.md
Name: spin_flip_scanner

Overview:
- Consumer stage directly downstream of the energy-monitor vector cache.
- On each accepted spin vector, XORs the new vector against the previously cached vector to form a flip mask.
- Streams the index and new value of every flipped spin, lowest index first, over a valid/ready interface, then reports the total flip count.
- The downstream energy update logic recomputes only the flipped spins.

Parameters:
- DATAWIDTH, 256: spin vector width; must be ≥2.
- IDXWIDTH, $clog2(DATAWIDTH): width of the flip index.
- CNTWIDTH, $clog2(DATAWIDTH+1): width of the flip count.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- en_i  input  1  block enable; low = synchronous clear to IDLE.
- data_valid_i  input  1  new vector valid; same signal that drives the cache's valid, gated externally by data_ready_o.
- data_ready_o  output  1  scanner can accept a vector.
- data_i  input  DATAWIDTH  new spin vector.
- data_cached_i  input  DATAWIDTH  previous cached vector; the cache's pure cached output, sampled in the handshake cycle.
- flip_valid_o  output  1  flip_idx_o / flip_val_o are valid.
- flip_ready_i  input  1  downstream accepts the current flip.
- flip_idx_o  output  IDXWIDTH  index of the flipped spin.
- flip_val_o  output  1  new value of that spin.
- flip_last_o  output  1  current flip is the last of this vector.
- flip_cnt_o  output  CNTWIDTH  number of flips emitted for the current/last vector.
- done_o  output  1  one-cycle pulse: vector fully scanned.
- busy_o  output  1  state != IDLE.
- perf_stall_cnt_o  output  32  stall counter (see Optional Feature).

Behaviour:
- Reset values:
  - State IDLE; mask_q, vec_q = 0; flip_cnt_o = 0.
  - All valid, last, done and busy outputs = 0; perf_stall_cnt_o = 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - data_ready_o = en_i.
  - Accept = en_i & data_valid_i & data_ready_o.
  - On accept: mask_q <= data_i ^ data_cached_i; vec_q <= data_i; flip_cnt_o <= 0.
  - If the mask is nonzero, go to SCAN; if zero, go to DONE.
- SCAN:
  - data_ready_o = 0; flip_valid_o = 1.
  - flip_idx_o = lowest set bit of mask_q; flip_val_o = vec_q[flip_idx_o].
  - flip_last_o = (mask_q & (mask_q-1)) == 0.
  - On flip_valid_o & flip_ready_i: clear that bit of mask_q and increment flip_cnt_o.
  - If flip_last_o is set at acceptance, go to DONE.
  - Outputs hold stable while flip_ready_i is low (AXI-style; no combinational path from flip_ready_i to flip_valid_o or flip_idx_o).
  - Throughput: one flip per cycle with flip_ready_i tied high.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE; data_ready_o = 0 in DONE.
  - Latency from vector accept to done_o: N+1 cycles for N flips (no stalls); 1 cycle when N = 0.
- flip_cnt_o holds its final value until the next accepted vector.
- en_i low in any state:
  - Next cycle state is IDLE; mask_q, vec_q and flip_cnt_o are cleared; no done_o pulse.
  - flip_valid_o drops in the same cycle en_i is low. A flip handshake in that cycle is ignored.
- flip_cnt_o saturates at DATAWIDTH by construction; all DATAWIDTH bits flipped gives DATAWIDTH emissions.
- Asynchronous reset mid-SCAN: immediate return to reset values; any partial scan is discarded.
- Mask computation is width-exact; no sign extension or truncation.

Optional Feature:
- Macro: SPIN_FLIP_SCANNER_PERF_EN.
- Defined:
  - perf_stall_cnt_o is a 32-bit counter, incremented each cycle where flip_valid_o & !flip_ready_i.
  - Wraps at 2^32; cleared by reset or by en_i low.
- Undefined:
  - perf_stall_cnt_o is tied to 0; no counter flops are instantiated.

Test Plan:
- DATAWIDTH=8, cached=0x00, data=0xA5, flip_ready_i=1:
  - Indices 0,2,5,7 emitted on consecutive cycles with flip_val_o=1, flip_last_o only on 7.
  - done_o pulses next cycle; flip_cnt_o=4.
- cached=0x3C, data=0x3C:
  - No flip_valid_o; done_o the cycle after accept; flip_cnt_o=0.
- cached=0xFF, data=0x7F, flip_ready_i low for 3 cycles:
  - idx=7, val=0 held stable for all 3 cycles.
  - Accepted on the 4th cycle; flip_last_o=1; perf_stall_cnt_o=3 with PERF_EN.
- DATAWIDTH=256, cached=0, data=all-ones:
  - 256 flips, indices 0..255 in order; flip_cnt_o=256; flip_last_o only on 255.
- cached=0x00, data=0xF0; drop en_i after the 2nd flip accept:
  - flip_valid_o=0 immediately; state IDLE, flip_cnt_o=0, no done_o.
  - With en_i high again, data_ready_o=1.
- Assert rst_ni low mid-SCAN (data=0x0F):
  - All outputs at reset values asynchronously; after release the next vector scans from a clean mask.
